// File: rtl/ray_cast_pkg.sv
// Shared types and defaults for the nearest-wall ray caster.
package ray_cast_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_FRAC   = 8;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, MUL, TEST, DIV_T, CMP, DIV_U, UPDATE, DONE
    } state_t;

    // Saturated quotient for a w-bit result field (all ones).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/ray_div_serial.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH cycles per divide.
module ray_div_serial #(
    parameter int WIDTH = 16,
    parameter int DW    = 2*WIDTH+3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DW+WIDTH-1:0]   num,
    input  logic [DW-1:0]         den,
    output logic                  done,
    output logic [WIDTH-1:0]      quo,
    output logic                  sat
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    logic [DW-1:0]    rem;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [DW:0]      trial;
    logic             ge;

    assign trial = {rem, lo[WIDTH-1]};
    assign ge    = trial >= {1'b0, den};
    assign done  = run && (cnt == LAST);

    // Quotient only fits WIDTH bits when the upper numerator is below den;
    // otherwise sat flags it and the raw bits are meaningless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
            lo  <= '0;
            quo <= '0;
            sat <= 1'b0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            rem <= num[DW+WIDTH-1:WIDTH];
            lo  <= num[WIDTH-1:0];
            quo <= '0;
            sat <= num[DW+WIDTH-1:WIDTH] >= den;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            rem <= DW'(ge ? trial - {1'b0, den} : trial);
            lo  <= lo << 1;
            quo <= {quo[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/ray_cast_nearest.sv
// Scans a wall list for one ray at a time and returns the nearest intersection.
module ray_cast_nearest
    import ray_cast_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ray_valid,
    output logic                     ray_ready,
    input  logic signed [WIDTH-1:0]  x1,
    input  logic signed [WIDTH-1:0]  y1,
    input  logic signed [WIDTH-1:0]  x2,
    input  logic signed [WIDTH-1:0]  y2,
    input  logic [ADDR_W:0]          num_walls,
    output logic [ADDR_W-1:0]        wall_addr,
    input  logic [4*WIDTH-1:0]       wall_data,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     hit,
    output logic [WIDTH-1:0]         ray_distance,
    output logic [WIDTH-1:0]         uv_x,
    output logic [ADDR_W-1:0]        wall_idx,
    output logic                     busy
);
    localparam int PW = 2*WIDTH+3;
    localparam int NW = PW+WIDTH;
    localparam int DW = WIDTH+1;
    localparam logic [WIDTH-1:0] QSAT = WIDTH'(sat_max(WIDTH));

    state_t state;

    logic signed [WIDTH-1:0] rx1, ry1, rx2, ry2, wx3, wy3, wx4, wy4;
    logic [ADDR_W:0]         nw;
    logic [ADDR_W-1:0]       idx;
    logic signed [PW-1:0]    den, tn, un;
    logic [WIDTH-1:0]        q_t;
    logic                    best_hit;
    logic [WIDTH-1:0]        best_t, best_u;
    logic [ADDR_W-1:0]       best_idx;

    assign ray_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    logic signed [DW-1:0] dx12, dy12, dx13, dy13, dx34, dy34;
    assign dx12 = DW'(rx1) - DW'(rx2);
    assign dy12 = DW'(ry1) - DW'(ry2);
    assign dx13 = DW'(rx1) - DW'(wx3);
    assign dy13 = DW'(ry1) - DW'(wy3);
    assign dx34 = DW'(wx3) - DW'(wx4);
    assign dy34 = DW'(wy3) - DW'(wy4);

    logic signed [PW-1:0] den_c, tn_c, un_c;
    assign den_c = PW'(dx12)*PW'(dy34) - PW'(dy12)*PW'(dx34);
    assign tn_c  = PW'(dx13)*PW'(dy34) - PW'(dy13)*PW'(dx34);
    assign un_c  = PW'(dy12)*PW'(dx13) - PW'(dx12)*PW'(dy13);

    // Normalise to den>0 so the range tests and the unsigned divider apply.
    logic                 neg, cand;
    logic signed [PW-1:0] den_a, tn_a, un_a;
    assign neg   = den[PW-1];
    assign den_a = neg ? -den : den;
    assign tn_a  = neg ? -tn  : tn;
    assign un_a  = neg ? -un  : un;
    assign cand  = (den_a != '0) && !tn_a[PW-1] && !un_a[PW-1] && (un_a <= den_a);

    logic              div_start, div_done, div_sat;
    logic [NW-1:0]     div_num;
    logic [PW-1:0]     div_den;
    logic [WIDTH-1:0]  div_q, div_res;
    logic              closer, more, wall_end;

    assign div_res   = div_sat ? QSAT : div_q;
    assign closer    = !best_hit || (div_res < best_t);
    assign div_start = (state == TEST && cand) || (state == CMP && closer);
    assign div_num   = (state == TEST) ? {{(WIDTH-FRAC){1'b0}}, tn_a, {FRAC{1'b0}}}
                                       : {un, {WIDTH{1'b0}}};
    assign div_den   = (state == TEST) ? den_a : den;
    assign more      = ({1'b0, idx} + 1'b1) < nw;
    assign wall_end  = (state == TEST && !cand) || (state == CMP && !closer) ||
                       (state == UPDATE);

    ray_div_serial #(.WIDTH(WIDTH), .DW(PW)) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quo   (div_q),
        .sat   (div_sat)
    );

    // Best-so-far after this cycle; only UPDATE changes it.
    logic              nb_hit;
    logic [WIDTH-1:0]  nb_t, nb_u;
    logic [ADDR_W-1:0] nb_idx;
    always_comb begin
        nb_hit = best_hit;
        nb_t   = best_t;
        nb_u   = best_u;
        nb_idx = best_idx;
        if (state == UPDATE) begin
            nb_hit = 1'b1;
            nb_t   = q_t;
            nb_u   = div_res;
            nb_idx = idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            {rx1, ry1, rx2, ry2} <= '0;
            {wx3, wy3, wx4, wy4} <= '0;
            nw           <= '0;
            idx          <= '0;
            den          <= '0;
            tn           <= '0;
            un           <= '0;
            q_t          <= '0;
            best_hit     <= 1'b0;
            best_t       <= '0;
            best_u       <= '0;
            best_idx     <= '0;
            wall_addr    <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            ray_distance <= '0;
            uv_x         <= '0;
            wall_idx     <= '0;
        end else begin
            case (state)
                IDLE: if (ray_valid && ray_ready) begin
                    {rx1, ry1, rx2, ry2} <= {x1, y1, x2, y2};
                    nw       <= num_walls;
                    idx      <= '0;
                    best_hit <= 1'b0;
                    best_t   <= '0;
                    best_u   <= '0;
                    best_idx <= '0;
                    if (num_walls == '0) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        hit          <= 1'b0;
                        ray_distance <= '0;
                        uv_x         <= '0;
                        wall_idx     <= '0;
                    end else begin
                        wall_addr <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH:  state <= LOAD;
                LOAD: begin
                    {wx3, wy3, wx4, wy4} <= wall_data;
                    state <= MUL;
                end
                MUL: begin
                    den   <= den_c;
                    tn    <= tn_c;
                    un    <= un_c;
                    state <= TEST;
                end
                TEST: begin
                    den <= den_a;
                    un  <= un_a;
                    if (cand) state <= DIV_T;
                end
                DIV_T:  if (div_done) state <= CMP;
                CMP: if (closer) begin
                    q_t   <= div_res;
                    state <= DIV_U;
                end
                DIV_U:  if (div_done) state <= UPDATE;
                UPDATE: begin
                    best_hit <= nb_hit;
                    best_t   <= nb_t;
                    best_u   <= nb_u;
                    best_idx <= nb_idx;
                end
                DONE: if (result_ready) begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Advance to the next wall in the same cycle the current one resolves.
            if (wall_end) begin
                if (more) begin
                    idx       <= idx + 1'b1;
                    wall_addr <= idx + 1'b1;
                    state     <= FETCH;
                end else begin
                    state        <= DONE;
                    result_valid <= 1'b1;
                    hit          <= nb_hit;
                    ray_distance <= nb_t;
                    uv_x         <= nb_u;
                    wall_idx     <= nb_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ray_cast_nearest.sv
// Directed vectors for ray_cast_nearest with a synchronous-read wall memory model.
module tb_ray_cast_nearest;
    localparam int W = 16;
    localparam int A = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                ray_valid = 1'b0;
    logic                ray_ready;
    logic signed [W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [A:0]          num_walls = '0;
    logic [A-1:0]        wall_addr;
    logic [4*W-1:0]      wall_data = '0;
    logic                result_valid;
    logic                result_ready = 1'b0;
    logic                hit;
    logic [W-1:0]        ray_distance, uv_x;
    logic [A-1:0]        wall_idx;
    logic                busy;

    logic [4*W-1:0] mem [0:63];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) wall_data <= mem[wall_addr];

    ray_cast_nearest #(.WIDTH(W), .FRAC(8), .ADDR_W(A)) dut (
        .clk(clk), .reset(reset), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .num_walls(num_walls),
        .wall_addr(wall_addr), .wall_data(wall_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .hit(hit), .ray_distance(ray_distance), .uv_x(uv_x),
        .wall_idx(wall_idx), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic set_wall(input int i, input int a, input int b, input int c, input int d);
        mem[i] = {16'(a), 16'(b), 16'(c), 16'(d)};
    endtask

    task automatic send(input int a, input int b, input int c, input int d, input int n);
        @(negedge clk);
        x1 = 16'(a); y1 = 16'(b); x2 = 16'(c); y2 = 16'(d);
        num_walls = 7'(n);
        ray_valid = 1'b1;
        @(posedge clk);
        #1 ray_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!result_valid && lat < 2000) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic ack();
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
    endtask

    task automatic run(input string tag, input int a, input int b, input int c, input int d,
                       input int n, input int lat_e, input logic h_e,
                       input logic [W-1:0] d_e, input logic [W-1:0] u_e, input logic [A-1:0] i_e);
        int lat;
        send(a, b, c, d, n);
        wait_res(lat);
        chk({tag, ".lat"}, 64'(lat), 64'(lat_e));
        chk({tag, ".hit"}, 64'(hit), 64'(h_e));
        chk({tag, ".dist"}, 64'(ray_distance), 64'(d_e));
        chk({tag, ".uv"}, 64'(uv_x), 64'(u_e));
        chk({tag, ".idx"}, 64'(wall_idx), 64'(i_e));
        ack();
    endtask

    initial begin
        int lat, bad;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", 64'(ray_ready), 64'd0);
        chk("rst.rv", 64'(result_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.hit", 64'(hit), 64'd0);
        @(negedge clk) reset = 1'b0;
        #1 chk("post_rst.ready", 64'(ray_ready), 64'd1);

        // single wall straight ahead, nearest so full 38-cycle path
        set_wall(0, 4, -2, 4, 2);
        run("t1", 0, 0, 1, 0, 1, 38, 1'b1, 16'h0400, 16'h8000, 6'd0);

        // nearer wall at idx1, parallel and behind walls missed
        set_wall(1, 2, -2, 2, 2);
        set_wall(2, 0, 1, 5, 1);
        set_wall(3, -3, -1, -3, 1);
        run("t2", 0, 0, 1, 0, 4, 84, 1'b1, 16'h0200, 16'h8000, 6'd1);

        // tie: lower index wins, second wall costs 21
        set_wall(1, 4, -2, 4, 2);
        run("tie", 0, 0, 1, 0, 2, 59, 1'b1, 16'h0400, 16'h8000, 6'd0);

        set_wall(0, 300, -1, 300, 1);
        run("tsat", 0, 0, 1, 0, 1, 38, 1'b1, 16'hFFFF, 16'h8000, 6'd0);
        set_wall(0, 4, 0, 4, 2);
        run("u0", 0, 0, 1, 0, 1, 38, 1'b1, 16'h0400, 16'h0000, 6'd0);
        set_wall(0, 4, -2, 4, 0);
        run("u1", 0, 0, 1, 0, 1, 38, 1'b1, 16'h0400, 16'hFFFF, 6'd0);
        // reversed wall gives den<0; u=2/3
        set_wall(0, 4, 2, 4, -1);
        run("negden", 0, 0, 1, 0, 1, 38, 1'b1, 16'h0400, 16'hAAAA, 6'd0);
        // t=4/3 truncated: 1024/3 = 341
        set_wall(0, 4, -2, 4, 2);
        run("frac", 0, 0, 3, 0, 1, 38, 1'b1, 16'h0155, 16'h8000, 6'd0);

        run("nw0", 0, 0, 1, 0, 0, 0, 1'b0, 16'h0000, 16'h0000, 6'd0);
        set_wall(1, 2, -2, 2, 2);
        set_wall(2, 0, 1, 5, 1);
        run("zero_ray", 5, 5, 5, 5, 3, 12, 1'b0, 16'h0000, 16'h0000, 6'd0);

        // backpressure: result held for 10 cycles
        send(0, 0, 1, 0, 1);
        wait_res(lat);
        chk("hold.lat", 64'(lat), 64'd38);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (hit !== 1'b1 || ray_distance !== 16'h0400 || uv_x !== 16'h8000 ||
                wall_idx !== 6'd0 || result_valid !== 1'b1 || ray_ready !== 1'b0) bad++;
        end
        chk("hold.stable", 64'(bad), 64'd0);
        ack();
        chk("ack.busy", 64'(busy), 64'd0);
        chk("ack.rv", 64'(result_valid), 64'd0);
        chk("ack.ready", 64'(ray_ready), 64'd1);
        chk("ack.hit_kept", 64'(hit), 64'd1);
        chk("ack.dist_kept", 64'(ray_distance), 64'h0400);

        // reset during the second wall's DIV_T
        set_wall(1, 4, -2, 4, 2);
        send(0, 0, 1, 0, 2);
        repeat (45) @(posedge clk);
        #1;
        chk("mid.busy", 64'(busy), 64'd1);
        chk("mid.addr", 64'(wall_addr), 64'd1);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.rv", 64'(result_valid), 64'd0);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.hit", 64'(hit), 64'd0);
        chk("abort.dist", 64'(ray_distance), 64'd0);
        chk("abort.uv", 64'(uv_x), 64'd0);
        chk("abort.addr", 64'(wall_addr), 64'd0);
        chk("abort.ready", 64'(ray_ready), 64'd0);
        @(negedge clk) reset = 1'b0;
        run("after_rst", 0, 0, 1, 0, 1, 38, 1'b1, 16'h0400, 16'h8000, 6'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ray_cast_nearest.md
Name: ray_cast_nearest

Overview:
- Sequential, parametrised successor to the single-segment combinational ray/wall intersector.
- Accepts one ray per handshake and scans a wall list held in a synchronous-read wall memory.
- Intersects the ray with each wall, keeps the nearest hit, and returns distance, texture coordinate and wall index.
- Feeds the column renderer; one ray per screen column.

Parameters:
- WIDTH, 16: signed coordinate width; also the width of ray_distance and uv_x.
- FRAC, 8: fractional bits of ray_distance (distance is in units of ray length, QWIDTH-FRAC.FRAC).
- ADDR_W, 6: wall memory address width; max 2^ADDR_W walls.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ray_valid  in  1  ray presented
- ray_ready  out  1  high only in IDLE and not in reset
- x1,y1,x2,y2  in  WIDTH each, signed  ray origin and a second point along the ray
- num_walls  in  ADDR_W+1  walls to scan; sampled with the ray
- wall_addr  out  ADDR_W  wall memory read address
- wall_data  in  4*WIDTH  {x3,y3,x4,y4} MSB-first; valid one cycle after wall_addr
- result_valid  out  1  result held until accepted
- result_ready  in  1  consumer accepts the result
- hit  out  1  any wall intersected
- ray_distance  out  WIDTH  nearest t, unsigned fixed point, saturating
- uv_x  out  WIDTH  u at nearest hit, unsigned 0.WIDTH, saturating
- wall_idx  out  ADDR_W  index of the nearest wall
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - State goes to IDLE.
  - All outputs are 0.
  - ray_ready = (state==IDLE) && !reset, so it is 0 during reset and 1 in the first cycle after reset.
  - Reset mid-scan aborts the scan. No result is produced.
- Accept: a ray is accepted when ray_valid && ray_ready. Ray and num_walls are registered, best is cleared, idx=0.
  - If num_walls==0, go to DONE with hit=0.
  - Otherwise go to FETCH.
- Per-wall state sequence (one cycle each unless stated):
  - FETCH: drive wall_addr=idx.
  - LOAD: register wall_data.
  - MUL: register den=(x1-x2)(y3-y4)-(y1-y2)(x3-x4), tn=(x1-x3)(y3-y4)-(y1-y3)(x3-x4), un=-((x1-x2)(y1-y3)-(y1-y2)(x1-x3)). Full width is 2*WIDTH+3 signed, with no truncation.
  - TEST: if den<0, negate den, tn and un. The wall is a candidate iff den!=0 && tn>=0 && 0<=un<=den. A non-candidate goes to NEXT.
  - DIV_T (WIDTH cycles): q_t = (tn<<FRAC)/den, truncated. If tn >= den<<(WIDTH-FRAC), q_t = 2^WIDTH-1; the cycle count is unchanged.
  - CMP: if !best_hit || q_t < best_t (strict), go to DIV_U; else go to NEXT.
  - DIV_U (WIDTH cycles): q_u = (un<<WIDTH)/den. If un==den, q_u saturates to 2^WIDTH-1.
  - UPDATE: best <= {1, q_t, q_u, idx}.
  - NEXT: idx++. Go to FETCH if idx+1 < num_walls, else DONE. NEXT is merged into the last cycle of the preceding state and costs no cycle.
- Per-wall cycle cost, including the transition:
  - miss: 4
  - hit, not closer: WIDTH+5
  - hit, closer: 2*WIDTH+6
  - With WIDTH=16 these are 4 / 21 / 38.
- DONE:
  - Drive result_valid=1 with outputs = best.
  - Outputs are stable until result_ready.
  - On the handshake, the next cycle is IDLE with result_valid=0. Output data values are retained.
- Degenerate inputs:
  - Zero-length ray: den=0 for every wall, so hit=0.
  - Collinear or parallel wall: miss.
  - Ties: the lower index wins.
  - Endpoints count as hits: u==0 gives uv_x=0; u==1 gives uv_x=0xFFFF.
- wall_addr holds its last value outside FETCH/LOAD.

Decomposition:
- ray_cast_pkg holds:
  - state enum (IDLE, FETCH, LOAD, MUL, TEST, DIV_T, CMP, DIV_U, UPDATE, DONE)
  - default WIDTH, FRAC and ADDR_W
  - the saturation constant
- Sub-module ray_div_serial: unsigned restoring divider.
  - Operands: numerator 2*WIDTH+3+WIDTH bits, denominator 2*WIDTH+3 bits.
  - Output: WIDTH-bit quotient with a sat flag.
  - start/done handshake, exactly WIDTH cycles.
  - Instantiated once and shared by DIV_T and DIV_U.

Test Plan (WIDTH=16, FRAC=8):
- Ray (0,0)->(1,0); wall0 (4,-2)-(4,2); num_walls=1 -> hit=1, ray_distance=0x0400, uv_x=0x8000, wall_idx=0; result_valid exactly 38 cycles after accept.
- Walls: 0 (4,-2)-(4,2), 1 (2,-2)-(2,2), 2 (0,1)-(5,1) parallel, 3 (-3,-1)-(-3,1) behind -> hit=1, distance=0x0200, uv_x=0x8000, wall_idx=1.
- Two identical walls (4,-2)-(4,2) at idx 0,1 -> wall_idx=0; idx1 costs 21 cycles. Wall (300,-1)-(300,1) -> hit=1, ray_distance=0xFFFF. Wall (4,0)-(4,2) -> uv_x=0x0000.
- num_walls=0 -> result_valid the cycle after accept, hit=0. Zero-length ray (5,5)->(5,5) with 3 walls -> hit=0.
- Hold result_ready=0 for 10 cycles -> outputs stable and ray_ready=0; on accept, IDLE the next cycle.
- Assert reset during DIV_T -> next edge: result_valid=0, busy=0, all outputs 0. A new ray after release completes correctly.
